// File: rtl/hazard_ctrl_if.sv
// Hazard-controller bundle: the hazard inputs seen by the controller and the
// stage-register enables and flush lines it drives back into the pipeline.
interface hazard_ctrl_if;
   logic       IM_stall;
   logic       DM_stall;
   logic       branch_taken;
   logic       EX_MemRead;
   logic [4:0] EX_rdaddr;
   logic [4:0] rs1addr;
   logic [4:0] rs2addr;
   logic       PCWrite;
   logic       IFID_RegWrite;
   logic       IFFlush;
   logic       IDFlush;
   logic       IDEXE_RegWrite;
   logic       EXEMEM_RegWrite;
   logic       MEMWB_RegWrite;

   modport master (
      output IM_stall, DM_stall, branch_taken, EX_MemRead, EX_rdaddr, rs1addr, rs2addr,
      input  PCWrite, IFID_RegWrite, IFFlush, IDFlush, IDEXE_RegWrite,
             EXEMEM_RegWrite, MEMWB_RegWrite
   );

   modport slave (
      input  IM_stall, DM_stall, branch_taken, EX_MemRead, EX_rdaddr, rs1addr, rs2addr,
      output PCWrite, IFID_RegWrite, IFFlush, IDFlush, IDEXE_RegWrite,
             EXEMEM_RegWrite, MEMWB_RegWrite
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory stall > taken-branch flush > load-use
// bubble, with a branch flush held pending across stalls and saturating hazard counters.
module hazard_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   hazard_ctrl_if.slave     hz,
   input  logic             cnt_clr,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [0:0] {
      RUN  = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t           state_q, state_d;
   logic             pend_flush_q, pend_flush_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   logic mem_stall_s, take_flush_s, load_use_s;
   logic pc_we_s, ifid_we_s, if_flush_s, id_flush_s, idex_we_s, exmem_we_s, memwb_we_s;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (&v) begin
         return v;
      end else begin
         return v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   endfunction

   assign mem_stall_s  = hz.IM_stall | hz.DM_stall;
   assign take_flush_s = hz.branch_taken | pend_flush_q;
   assign load_use_s   = hz.EX_MemRead & (hz.EX_rdaddr != 5'd0) &
                         ((hz.EX_rdaddr == hz.rs1addr) | (hz.EX_rdaddr == hz.rs2addr));

   // State register, pending branch flush and hazard counters
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= RUN;
         pend_flush_q <= 1'b0;
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         state_q      <= state_d;
         pend_flush_q <= pend_flush_d;
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   // Next-state, hazard arbitration and raw enable/flush decode
   always_comb begin
      state_d      = state_q;
      pend_flush_d = pend_flush_q;
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      pc_we_s      = 1'b1;
      ifid_we_s    = 1'b1;
      if_flush_s   = 1'b0;
      id_flush_s   = 1'b0;
      idex_we_s    = 1'b1;
      exmem_we_s   = 1'b1;
      memwb_we_s   = 1'b1;

      case (state_q)
         RUN: begin
            if (mem_stall_s) state_d = WAIT;
            else             state_d = RUN;
         end
         WAIT: begin
            if (mem_stall_s) state_d = WAIT;
            else             state_d = RUN;
         end
         default: state_d = RUN;
      endcase

      if (mem_stall_s) begin
         pc_we_s     = 1'b0;
         ifid_we_s   = 1'b0;
         idex_we_s   = 1'b0;
         exmem_we_s  = 1'b0;
         memwb_we_s  = 1'b0;
         stall_cnt_d = sat_inc(stall_cnt_q);
         if (hz.branch_taken) pend_flush_d = 1'b1;
         else                 pend_flush_d = pend_flush_q;
      end else if (take_flush_s) begin
         // Flush wins over load-use: the dependent instruction is squashed anyway
         if_flush_s   = 1'b1;
         id_flush_s   = 1'b1;
         pend_flush_d = 1'b0;
         flush_cnt_d  = sat_inc(flush_cnt_q);
      end else if (load_use_s) begin
         pc_we_s      = 1'b0;
         ifid_we_s    = 1'b0;
         id_flush_s   = 1'b1;
         bubble_cnt_d = sat_inc(bubble_cnt_q);
      end else begin
         pend_flush_d = pend_flush_q;
      end

      if (cnt_clr) begin
         stall_cnt_d  = '0;
         flush_cnt_d  = '0;
         bubble_cnt_d = '0;
      end else begin
         stall_cnt_d  = stall_cnt_d;
      end
   end

   // Reset forces every enable and flush low so nothing loads while the core is held
   assign hz.PCWrite         = pc_we_s    & rst;
   assign hz.IFID_RegWrite   = ifid_we_s  & rst;
   assign hz.IFFlush         = if_flush_s & rst;
   assign hz.IDFlush         = id_flush_s & rst;
   assign hz.IDEXE_RegWrite  = idex_we_s  & rst;
   assign hz.EXEMEM_RegWrite = exmem_we_s & rst;
   assign hz.MEMWB_RegWrite  = memwb_we_s & rst;

   assign stall_cnt  = stall_cnt_q;
   assign flush_cnt  = flush_cnt_q;
   assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a single-cycle vector table plus stall/flush,
// saturation and reset-mid-stall sequences, all with hand-computed expectations.
module tb_hazard_ctrl;
   localparam int CNT_W = 16;

   // {PCWrite, IFID_RegWrite, IFFlush, IDFlush, IDEXE_RegWrite, EXEMEM_RegWrite, MEMWB_RegWrite}
   localparam logic [6:0] C_NORM  = 7'b1100111;
   localparam logic [6:0] C_STALL = 7'b0000000;
   localparam logic [6:0] C_FLUSH = 7'b1111111;
   localparam logic [6:0] C_BUBB  = 7'b0001111;

   logic clk;
   logic rst;
   logic cnt_clr;
   logic [CNT_W-1:0] stall_cnt, flush_cnt, bubble_cnt;

   hazard_ctrl_if hif ();

   hazard_ctrl #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst        (rst),
      .hz         (hif),
      .cnt_clr    (cnt_clr),
      .stall_cnt  (stall_cnt),
      .flush_cnt  (flush_cnt),
      .bubble_cnt (bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       im, dm, br, mr;
      logic [4:0] rd, rs1, rs2;
      logic [6:0] exp_ctl;
   } vec_t;

   vec_t vecs [12];
   int n_vec = 0;
   int n_err = 0;

   function automatic logic [6:0] ctl();
      return {hif.PCWrite, hif.IFID_RegWrite, hif.IFFlush, hif.IDFlush,
              hif.IDEXE_RegWrite, hif.EXEMEM_RegWrite, hif.MEMWB_RegWrite};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic im, input logic dm, input logic br, input logic mr,
                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      hif.IM_stall     = im;
      hif.DM_stall     = dm;
      hif.branch_taken = br;
      hif.EX_MemRead   = mr;
      hif.EX_rdaddr    = rd;
      hif.rs1addr      = rs1;
      hif.rs2addr      = rs2;
   endtask

   // Check controls at the negedge, then advance to just after the next posedge
   task automatic cyc(input string name, input logic [6:0] exp);
      @(negedge clk);
      chk(name, {25'd0, ctl()}, {25'd0, exp});
      @(posedge clk);
      #1;
   endtask

   initial begin
      vecs[0]  = '{"idle",        1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, C_NORM};
      vecs[1]  = '{"lu_rs1",      1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd1, C_BUBB};
      vecs[2]  = '{"lu_rs2",      1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd2, 5'd5, C_BUBB};
      vecs[3]  = '{"lu_x0",       1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, C_NORM};
      vecs[4]  = '{"nonload",     1'b0, 1'b0, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, C_NORM};
      vecs[5]  = '{"load_nodep",  1'b0, 1'b0, 1'b0, 1'b1, 5'd7, 5'd3, 5'd4, C_NORM};
      vecs[6]  = '{"branch",      1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, C_FLUSH};
      vecs[7]  = '{"branch_lu",   1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 5'd9, 5'd0, C_FLUSH};
      vecs[8]  = '{"im_stall",    1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, C_STALL};
      vecs[9]  = '{"dm_stall_lu", 1'b0, 1'b1, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, C_STALL};
      vecs[10] = '{"both_stall",  1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, C_STALL};
      vecs[11] = '{"post_stall",  1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, C_NORM};

      rst     = 1'b0;
      cnt_clr = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      @(negedge clk);
      chk("reset_ctl", {25'd0, ctl()}, 32'd0);
      chk("reset_cnt", {stall_cnt, flush_cnt | bubble_cnt}, 32'd0);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].im, vecs[i].dm, vecs[i].br, vecs[i].mr,
               vecs[i].rd, vecs[i].rs1, vecs[i].rs2);
         cyc(vecs[i].name, vecs[i].exp_ctl);
      end
      chk("tbl_bubble_cnt", {16'd0, bubble_cnt}, 32'd2);
      chk("tbl_flush_cnt",  {16'd0, flush_cnt},  32'd2);
      chk("tbl_stall_cnt",  {16'd0, stall_cnt},  32'd3);

      // Clear, then DM stall for 4 cycles with a branch pulse in cycle 2
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("clr_cnt", {stall_cnt, flush_cnt | bubble_cnt}, 32'd0);
      for (int c = 1; c <= 4; c++) begin
         drive(1'b0, 1'b1, (c == 2), 1'b0, 5'd0, 5'd0, 5'd0);
         cyc($sformatf("stall_c%0d", c), C_STALL);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc("pend_flush", C_FLUSH);
      chk("stall_cnt4", {16'd0, stall_cnt}, 32'd4);
      chk("flush_cnt1", {16'd0, flush_cnt}, 32'd1);
      cyc("after_pend", C_NORM);

      // Branch held high across the whole stall: still only one flush
      for (int c = 1; c <= 3; c++) begin
         drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
         cyc($sformatf("br_stall_c%0d", c), C_STALL);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc("held_flush", C_FLUSH);
      cyc("held_after", C_NORM);
      chk("flush_cnt2", {16'd0, flush_cnt}, 32'd2);

      // Saturation: 70000 consecutive bubbles
      drive(1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0);
      for (int c = 0; c < 70000; c++) @(posedge clk);
      #1;
      chk("bubble_sat", {16'd0, bubble_cnt}, 32'd65535);
      cyc("sat_bubble_ctl", C_BUBB);
      chk("bubble_hold", {16'd0, bubble_cnt}, 32'd65535);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      cnt_clr = 1'b1;
      @(posedge clk);
      #1;
      cnt_clr = 1'b0;
      chk("sat_clr", {16'd0, bubble_cnt}, 32'd0);

      // Reset mid-stall with a pending branch flush
      drive(1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0);
      cyc("rst_pre_stall", C_STALL);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
      rst = 1'b0;
      #1;
      chk("rst_ctl", {25'd0, ctl()}, 32'd0);
      chk("rst_cnt", {stall_cnt, flush_cnt | bubble_cnt}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc("rst_release", C_NORM);
      chk("rst_no_flush", {16'd0, flush_cnt}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
